// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and helpers for the round-robin mux arbiter
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at ptr, skipping excluded requesters
module rr_pick import mux_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  masked;
  logic [SW-1:0] k;
  int            s;

  always_comb begin
    win    = '0;
    idx    = '0;
    any    = 1'b0;
    k      = '0;
    s      = 0;
    masked = req & ~excl;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      k = SW'(s);
      if (!any && masked[k]) begin
        any    = 1'b1;
        idx    = k;
        win[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter owning the select of a shared N:1 data mux
// Optional forced release after TIMEOUT held cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter import mux_arb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15,
  localparam int SW     = sel_width(N_REQ)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  input  logic                i_done,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [SW-1:0]       o_sel,
  output logic                o_valid,
  output logic [DW-1:0]       o_data,
  output logic                o_timeout
);

  arb_state_e       state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d, sel_q, sel_d, next_ptr, pick_ptr, pick_idx;
  logic [N_REQ-1:0] gnt_q, gnt_d, pick_excl, pick_win;
  logic             valid_q, valid_d, pick_any, fire, forced, rel;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  assign fire = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign fire = 1'b0;
`endif

  assign rel       = (state_q == BUSY) && (i_done || !i_req[sel_q] || fire);
  assign forced    = fire && !i_done && i_req[sel_q];
  assign next_ptr  = (sel_q == SW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
  // A re-grant in the release cycle searches from the advanced pointer and skips the releaser.
  assign pick_ptr  = (state_q == BUSY) ? next_ptr : ptr_q;
  assign pick_excl = rel ? gnt_q : '0;

  rr_pick #(.N(N_REQ), .SW(SW)) u_pick (
    .req (i_req),
    .ptr (pick_ptr),
    .excl(pick_excl),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (rel && !pick_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    if ((state_q == IDLE) || rel) begin
      if (rel) ptr_d = next_ptr;
      if (pick_any) begin
        sel_d   = pick_idx;
        gnt_d   = pick_win;
        valid_d = 1'b1;
      end else begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    to_d  = 1'b0;
    if (state_q == BUSY) begin
      if (rel) begin
        cnt_d = '0;
        to_d  = forced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pick_any) begin
      cnt_d = '0;
    end
  end
  assign o_timeout = to_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_gnt   = gnt_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;
  assign o_data  = valid_q ? i_data[sel_q*DW +: DW] : '0;

endmodule
